// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-side bus of mem_access_ctrl.
// slave = the controller, master = the requester / memory model side.
interface mem_access_ctrl_if #(parameter int ADDR_W = 32);
   logic              Req_valid;
   logic              Req_ready;
   logic [6:0]        Opcode;
   logic [2:0]        Funct3;
   logic [ADDR_W-1:0] A;
   logic [31:0]       Wdata;
   logic [ADDR_W-1:0] Mem_addr;
   logic [31:0]       Mem_wdata;
   logic [3:0]        Dmem_enable;
   logic [3:0]        Imem_enable;
   logic [3:0]        Io_trans;
   logic              Io_recv;
   logic [31:0]       Dmem_rdata;
   logic [31:0]       Io_rdata;
   logic              Io_ready;
   logic              Resp_valid;
   logic [31:0]       Rdata;
   logic              Err;

   modport slave (
      input  Req_valid, Opcode, Funct3, A, Wdata, Dmem_rdata, Io_rdata, Io_ready,
      output Req_ready, Mem_addr, Mem_wdata, Dmem_enable, Imem_enable, Io_trans,
             Io_recv, Resp_valid, Rdata, Err
   );
   modport master (
      output Req_valid, Opcode, Funct3, A, Wdata, Dmem_rdata, Io_rdata, Io_ready,
      input  Req_ready, Mem_addr, Mem_wdata, Dmem_enable, Imem_enable, Io_trans,
             Io_recv, Resp_valid, Rdata, Err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller fanning requests out to dmem, imem and IO regions.
// Optional MEMCTL_MISALIGN_TRAP_EN: misaligned half/word accesses respond with Err.
module mem_access_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int IO_TIMEOUT = 15
) (
   input logic              clk,
   input logic              rst,
   mem_access_ctrl_if.slave bus
);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [7:0] TO_LAST  = 8'(IO_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, IO_WAIT, RESP} state_t;

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
      logic [31:0] s;
      logic [31:0] r;
      s = w >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{s[7]}}, s[7:0]};
         3'b100:  r = {24'b0, s[7:0]};
         3'b001:  r = {{16{s[15]}}, s[15:0]};
         3'b101:  r = {16'b0, s[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   state_t            state_q, state_d;
   logic              ld_q, ld_d, dld_q, dld_d, io_q, io_d, mis_q, mis_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]        dmem_en_q, dmem_en_d, imem_en_q, imem_en_d, io_trans_q, io_trans_d;
   logic              io_recv_q, io_recv_d, resp_valid_q, resp_valid_d, err_q, err_d;

   // Decode of the incoming request; captured into the _q fields on accept.
   logic              req_ld, req_st, req_mis, hit_d, hit_i, hit_io;
   logic [ADDR_W-1:0] a_eff;
   logic [3:0]        req_mask;
   logic [31:0]       req_wdata;

   always_comb begin
      req_ld  = (bus.Opcode == OP_LOAD);
      req_st  = (bus.Opcode == OP_STORE);
      a_eff   = bus.A;
      req_mis = 1'b0;
      case (bus.Funct3[1:0])
         2'b00: ;
         2'b01: begin
`ifdef MEMCTL_MISALIGN_TRAP_EN
            req_mis = bus.A[0];
`else
            a_eff[0] = 1'b0;
`endif
         end
         default: begin
`ifdef MEMCTL_MISALIGN_TRAP_EN
            req_mis = (bus.A[1:0] != 2'b00);
`else
            a_eff[1:0] = 2'b00;
`endif
         end
      endcase
      req_mis = req_mis && (req_ld || req_st);
      hit_d   = !a_eff[31] && a_eff[28];
      hit_i   = !a_eff[31] && a_eff[29];
      hit_io  = (a_eff[31:28] == 4'b1000);
      case (bus.Funct3[1:0])
         2'b00:   begin req_mask = 4'b0001 << a_eff[1:0];         req_wdata = {4{bus.Wdata[7:0]}};  end
         2'b01:   begin req_mask = 4'b0011 << {a_eff[1], 1'b0};   req_wdata = {2{bus.Wdata[15:0]}}; end
         default: begin req_mask = 4'b1111;                       req_wdata = bus.Wdata;            end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      ld_d         = ld_q;
      dld_d        = dld_q;
      io_d         = io_q;
      mis_d        = mis_q;
      f3_d         = f3_q;
      off_d        = off_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      dmem_en_d    = dmem_en_q;
      imem_en_d    = imem_en_q;
      io_trans_d   = io_trans_q;
      io_recv_d    = io_recv_q;
      resp_valid_d = 1'b0;
      err_d        = err_q;
      case (state_q)
         IDLE: begin
            err_d      = 1'b0;
            dmem_en_d  = '0;
            imem_en_d  = '0;
            io_trans_d = '0;
            io_recv_d  = 1'b0;
            if (bus.Req_valid) begin
               state_d = ACCESS;
               ld_d    = req_ld;
               dld_d   = req_ld && hit_d && !req_mis;
               io_d    = (req_ld || req_st) && hit_io && !req_mis;
               mis_d   = req_mis;
               f3_d    = bus.Funct3;
               off_d   = a_eff[1:0];
               addr_d  = a_eff;
               wdata_d = req_wdata;
               rdata_d = '0;
               if (req_st && !req_mis) begin
                  dmem_en_d  = hit_d  ? req_mask : 4'b0;
                  imem_en_d  = hit_i  ? req_mask : 4'b0;
                  io_trans_d = hit_io ? req_mask : 4'b0;
               end
               io_recv_d = req_ld && hit_io && !req_mis;
            end
         end
         ACCESS: begin
            dmem_en_d = '0;
            imem_en_d = '0;
            if (io_q) begin
               state_d = IO_WAIT;
               cnt_d   = '0;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               err_d        = mis_q;
            end
         end
         IO_WAIT: begin
            // Io_ready takes priority over the timeout on the final cycle.
            if (bus.Io_ready || cnt_q == TO_LAST) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               io_trans_d   = '0;
               io_recv_d    = 1'b0;
               err_d        = !bus.Io_ready;
               rdata_d      = (bus.Io_ready && ld_q) ? load_ext(bus.Io_rdata, f3_q, off_q) : '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ld_q         <= 1'b0;
         dld_q        <= 1'b0;
         io_q         <= 1'b0;
         mis_q        <= 1'b0;
         f3_q         <= '0;
         off_q        <= '0;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         dmem_en_q    <= '0;
         imem_en_q    <= '0;
         io_trans_q   <= '0;
         io_recv_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ld_q         <= ld_d;
         dld_q        <= dld_d;
         io_q         <= io_d;
         mis_q        <= mis_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         dmem_en_q    <= dmem_en_d;
         imem_en_q    <= imem_en_d;
         io_trans_q   <= io_trans_d;
         io_recv_q    <= io_recv_d;
         resp_valid_q <= resp_valid_d;
         err_q        <= err_d;
      end
   end

   // dmem read data arrives during RESP, so dmem loads bypass rdata_q.
   assign bus.Rdata       = (state_q == RESP && dld_q) ? load_ext(bus.Dmem_rdata, f3_q, off_q) : rdata_q;
   assign bus.Req_ready   = (state_q == IDLE);
   assign bus.Mem_addr    = addr_q;
   assign bus.Mem_wdata   = wdata_q;
   assign bus.Dmem_enable = dmem_en_q;
   assign bus.Imem_enable = imem_en_q;
   assign bus.Io_trans    = io_trans_q;
   assign bus.Io_recv     = io_recv_q;
   assign bus.Resp_valid  = resp_valid_q;
   assign bus.Err         = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever Resp_valid is seen.
module tb_mem_access_ctrl;
   localparam int TO = 15;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          held;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   resp_cnt = 0;
   int   io_lat = 0;
   int   io_cnt = 0;
   int   last_held = 0;
   exp_t sb[$];

   mem_access_ctrl_if #(.ADDR_W(32)) b();
   mem_access_ctrl #(.ADDR_W(32), .IO_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(b));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && b.Req_valid && b.Req_ready) acc_cyc <= cyc;
   end

   // IO responder: raises Io_ready once the strobe has been seen io_lat cycles.
   initial begin
      b.Io_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (b.Io_recv || (|b.Io_trans)) begin
            io_cnt++;
            b.Io_ready = (io_lat != 0 && io_cnt == io_lat);
         end else begin
            if (io_cnt != 0) last_held = io_cnt;
            io_cnt = 0;
            b.Io_ready = 1'b0;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (b.Resp_valid === 1'b1) begin
            resp_cnt++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp actual=1 expected=0");
            end else begin
               e = sb.pop_front();
               chk("rdata", b.Rdata, e.rdata);
               chk("err", 32'(b.Err), 32'(e.err));
               chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
               chk("io_held", 32'(last_held), 32'(e.held));
            end
         end
      end
   end

   task automatic req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] ea, input logic [3:0] ed,
                      input logic [3:0] ei, input logic [3:0] eio, input logic [31:0] ewd,
                      input logic [31:0] er, input logic ee, input int el, input int eh);
      exp_t e;
      e.rdata = er; e.err = ee; e.lat = el; e.held = eh;
      sb.push_back(e);
      @(posedge clk);
      #1;
      last_held   = 0;
      b.Req_valid = 1'b1;
      b.Opcode    = op;
      b.Funct3    = f3;
      b.A         = a;
      b.Wdata     = wd;
      @(posedge clk);
      #1;
      b.Req_valid = 1'b0;
      chk("ready_busy", 32'(b.Req_ready), 32'd0);
      chk("mem_addr", b.Mem_addr, ea);
      chk("dmem_en", 32'(b.Dmem_enable), 32'(ed));
      chk("imem_en", 32'(b.Imem_enable), 32'(ei));
      chk("io_trans", 32'(b.Io_trans), 32'(eio));
      if (ed != 0 || ei != 0 || eio != 0) chk("mem_wdata", b.Mem_wdata, ewd);
      @(posedge clk);
      #1;
      chk("dmem_en_1cyc", 32'(b.Dmem_enable), 32'd0);
      chk("imem_en_1cyc", 32'(b.Imem_enable), 32'd0);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL resp_timeout actual=none expected=response");
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      b.Req_valid = 1'b0; b.Opcode = '0; b.Funct3 = '0; b.A = '0; b.Wdata = '0;
      b.Dmem_rdata = 32'h0000_8000; b.Io_rdata = 32'h1234_5678;
      #12;
      chk("rst_ready", 32'(b.Req_ready), 32'd1);
      chk("rst_resp_valid", 32'(b.Resp_valid), 32'd0);
      chk("rst_err", 32'(b.Err), 32'd0);
      chk("rst_rdata", b.Rdata, 32'd0);
      chk("rst_mem_addr", b.Mem_addr, 32'd0);
      chk("rst_mem_wdata", b.Mem_wdata, 32'd0);
      chk("rst_enables", {20'd0, b.Dmem_enable, b.Imem_enable, b.Io_trans}, 32'd0);
      chk("rst_io_recv", 32'(b.Io_recv), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // stores
      req(ST, 3'b000, 32'h1000_0003, 32'h0000_00AB, 32'h1000_0003, 4'b1000, 4'b0000, 4'b0000,
          32'hABAB_ABAB, 32'h0, 1'b0, 2, 0);
      req(ST, 3'b010, 32'h3000_0000, 32'hDEAD_BEEF, 32'h3000_0000, 4'b1111, 4'b1111, 4'b0000,
          32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0);
      req(ST, 3'b001, 32'h1000_0002, 32'h1234_BEEF, 32'h1000_0002, 4'b1100, 4'b0000, 4'b0000,
          32'hBEEF_BEEF, 32'h0, 1'b0, 2, 0);
      // dmem loads
      req(LD, 3'b000, 32'h1000_0001, 32'h0, 32'h1000_0001, 4'b0, 4'b0, 4'b0, 32'h0,
          32'hFFFF_FF80, 1'b0, 2, 0);
      req(LD, 3'b100, 32'h1000_0001, 32'h0, 32'h1000_0001, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h0000_0080, 1'b0, 2, 0);
      b.Dmem_rdata = 32'h8765_4321;
      req(LD, 3'b001, 32'h1000_0002, 32'h0, 32'h1000_0002, 4'b0, 4'b0, 4'b0, 32'h0,
          32'hFFFF_8765, 1'b0, 2, 0);
      req(LD, 3'b101, 32'h1000_0002, 32'h0, 32'h1000_0002, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h0000_8765, 1'b0, 2, 0);
      req(LD, 3'b010, 32'h1000_0000, 32'h0, 32'h1000_0000, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h8765_4321, 1'b0, 2, 0);
      req(LD, 3'b000, 32'h1000_0003, 32'h0, 32'h1000_0003, 4'b0, 4'b0, 4'b0, 32'h0,
          32'hFFFF_FF87, 1'b0, 2, 0);
      req(LD, 3'b100, 32'h1000_0000, 32'h0, 32'h1000_0000, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h0000_0021, 1'b0, 2, 0);
      // IO: ready after 3 strobe cycles, store with ready after 2, timeout, ready on timeout cycle
      io_lat = 3;
      req(LD, 3'b010, 32'h8000_0004, 32'h0, 32'h8000_0004, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h1234_5678, 1'b0, 4, 3);
      io_lat = 2;
      req(ST, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h8000_0008, 4'b0, 4'b0, 4'b1111,
          32'hCAFE_F00D, 32'h0, 1'b0, 3, 2);
      io_lat = 0;
      req(LD, 3'b010, 32'h8000_0004, 32'h0, 32'h8000_0004, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h0, 1'b1, TO + 2, TO + 1);
      io_lat = TO + 1;
      req(LD, 3'b010, 32'h8000_0004, 32'h0, 32'h8000_0004, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h1234_5678, 1'b0, TO + 2, TO + 1);
      // no-ops: non-memory opcode, imem-only load
      req(7'b0010011, 3'b000, 32'h1000_0000, 32'hFFFF_FFFF, 32'h1000_0000, 4'b0, 4'b0, 4'b0,
          32'h0, 32'h0, 1'b0, 2, 0);
      req(LD, 3'b010, 32'h2000_0000, 32'h0, 32'h2000_0000, 4'b0, 4'b0, 4'b0, 32'h0,
          32'h0, 1'b0, 2, 0);
      // misaligned halfword store
`ifdef MEMCTL_MISALIGN_TRAP_EN
      req(ST, 3'b001, 32'h1000_0001, 32'h0000_5A5A, 32'h1000_0001, 4'b0, 4'b0, 4'b0,
          32'h5A5A_5A5A, 32'h0, 1'b1, 2, 0);
`else
      req(ST, 3'b001, 32'h1000_0001, 32'h0000_5A5A, 32'h1000_0000, 4'b0011, 4'b0, 4'b0,
          32'h5A5A_5A5A, 32'h0, 1'b0, 2, 0);
`endif

      // reset during IO_WAIT: strobe drops at once, no response afterwards
      io_lat = 0;
      @(posedge clk);
      #1;
      b.Req_valid = 1'b1; b.Opcode = LD; b.Funct3 = 3'b010; b.A = 32'h8000_0004;
      @(posedge clk);
      #1;
      b.Req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("io_recv_pre_rst", 32'(b.Io_recv), 32'd1);
      rst = 1'b1;
      #1;
      chk("io_recv_in_rst", 32'(b.Io_recv), 32'd0);
      chk("ready_in_rst", 32'(b.Req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      rc = resp_cnt;
      repeat (25) @(posedge clk);
      #1;
      chk("no_resp_after_rst", 32'(resp_cnt), 32'(rc));
      chk("ready_after_rst", 32'(b.Req_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
